// File: rtl/rope_pkg.sv
// Shared types and constants for the rope constraint sweep datapath.
// Coordinates are Q16.16 signed fixed point.
package rope_pkg;

    localparam int DATA_W    = 32;
    localparam int FRAC_BITS = 16;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_P0   = 3'd1;
    localparam logic [2:0] ST_P1   = 3'd2;
    localparam logic [2:0] ST_P2   = 3'd3;
    localparam logic [2:0] ST_P3   = 3'd4;
    localparam logic [2:0] ST_RUN  = 3'd5;
    localparam logic [2:0] ST_DONE = 3'd6;

    typedef struct packed {
        logic signed [DATA_W-1:0] x;
        logic signed [DATA_W-1:0] y;
    } pos_t;

endpackage

// File: rtl/particle_window.sv
// Three-particle sliding window (up, current, down) feeding the constraint unit.
// Priming loads fill one slot at a time; shift advances the window by one particle.
module particle_window #(
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_up,
    input  logic                     load_cur,
    input  logic                     load_down,
    input  logic                     shift,
    input  logic signed [DATA_W-1:0] rd_x,
    input  logic signed [DATA_W-1:0] rd_y,
    input  logic signed [DATA_W-1:0] res_x,
    input  logic signed [DATA_W-1:0] res_y,
    output logic signed [DATA_W-1:0] up_x,
    output logic signed [DATA_W-1:0] up_y,
    output logic signed [DATA_W-1:0] cur_x,
    output logic signed [DATA_W-1:0] cur_y,
    output logic signed [DATA_W-1:0] down_x,
    output logic signed [DATA_W-1:0] down_y
);

    always_ff @(posedge clk) begin
        if (rst) begin
            up_x   <= '0;
            up_y   <= '0;
            cur_x  <= '0;
            cur_y  <= '0;
            down_x <= '0;
            down_y <= '0;
        end else if (shift) begin
            // Gauss-Seidel: the freshly enforced particle becomes the next "up"
            up_x   <= res_x;
            up_y   <= res_y;
            cur_x  <= down_x;
            cur_y  <= down_y;
            down_x <= rd_x;
            down_y <= rd_y;
        end else begin
            if (load_up) begin
                up_x <= rd_x;
                up_y <= rd_y;
            end
            if (load_cur) begin
                cur_x <= rd_x;
                cur_y <= rd_y;
            end
            if (load_down) begin
                down_x <= rd_x;
                down_y <= rd_y;
            end
        end
    end

endmodule

// File: rtl/constraint_sweep_sequencer.sv
// Streams rope particles from position RAM through the constraint unit, one per cycle,
// writing enforced positions back and repeating the sweep NUM_SWEEPS times per start.
module constraint_sweep_sequencer #(
    parameter int N_PARTICLES = 16,
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = rope_pkg::DATA_W,
    parameter int NUM_SWEEPS  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     rd_en,
    output logic [ADDR_W-1:0]        rd_addr,
    input  logic signed [DATA_W-1:0] rd_x,
    input  logic signed [DATA_W-1:0] rd_y,
    output logic                     wr_en,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic signed [DATA_W-1:0] wr_x,
    output logic signed [DATA_W-1:0] wr_y,
    output logic signed [DATA_W-1:0] ec_up_x,
    output logic signed [DATA_W-1:0] ec_up_y,
    output logic signed [DATA_W-1:0] ec_x,
    output logic signed [DATA_W-1:0] ec_y,
    output logic signed [DATA_W-1:0] ec_down_x,
    output logic signed [DATA_W-1:0] ec_down_y,
    output logic                     ec_is_last,
    input  logic signed [DATA_W-1:0] ec_x_in,
    input  logic signed [DATA_W-1:0] ec_y_in
);

    import rope_pkg::*;

    localparam int SW_W = (NUM_SWEEPS > 1) ? $clog2(NUM_SWEEPS) : 1;
    localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(N_PARTICLES - 1);
    localparam logic [ADDR_W+1:0] LAST_RD    = (ADDR_W + 2)'(N_PARTICLES - 1);
    localparam logic [SW_W-1:0]   LAST_SWEEP = SW_W'(NUM_SWEEPS - 1);

    logic [2:0]        state_r;
    logic [2:0]        state_nxt;
    logic [ADDR_W-1:0] idx_r;
    logic [SW_W-1:0]   sweep_r;
    logic              run;
    logic              at_last;
    logic              last_sweep;
    logic [ADDR_W+1:0] rd_ahead;

    logic signed [DATA_W-1:0] up_x, up_y, cur_x, cur_y, down_x, down_y;

    assign run        = (state_r == ST_RUN);
    assign at_last    = (idx_r == LAST_IDX);
    assign last_sweep = (sweep_r == LAST_SWEEP);
    // Extra headroom so i+3 past the end of the rope does not wrap into a valid address
    assign rd_ahead   = {2'b00, idx_r} + (ADDR_W + 2)'(3);

    always_comb begin
        state_nxt = state_r;
        case (state_r)
            ST_IDLE: if (start) state_nxt = ST_P0;
            ST_P0:   state_nxt = ST_P1;
            ST_P1:   state_nxt = ST_P2;
            ST_P2:   state_nxt = ST_P3;
            ST_P3:   state_nxt = ST_RUN;
            ST_RUN:  if (at_last) state_nxt = last_sweep ? ST_DONE : ST_P0;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            idx_r   <= '0;
            sweep_r <= '0;
        end else begin
            state_r <= state_nxt;
            if (state_r == ST_P3) begin
                idx_r <= ADDR_W'(1);
            end else if (run) begin
                idx_r <= idx_r + ADDR_W'(1);
            end
            if (state_r == ST_IDLE && start) begin
                sweep_r <= '0;
            end else if (run && at_last && !last_sweep) begin
                sweep_r <= sweep_r + SW_W'(1);
            end
        end
    end

    always_comb begin
        rd_en   = 1'b0;
        rd_addr = '0;
        case (state_r)
            ST_P0: begin rd_en = 1'b1; rd_addr = ADDR_W'(0); end
            ST_P1: begin rd_en = 1'b1; rd_addr = ADDR_W'(1); end
            ST_P2: begin rd_en = 1'b1; rd_addr = ADDR_W'(2); end
            ST_P3: begin rd_en = 1'b1; rd_addr = ADDR_W'(3); end
            ST_RUN: begin
                rd_en   = (rd_ahead <= LAST_RD);
                rd_addr = rd_ahead[ADDR_W-1:0];
            end
            default: ;
        endcase
    end

    particle_window #(
        .DATA_W (DATA_W)
    ) u_window (
        .clk       (clk),
        .rst       (rst),
        .load_up   (state_r == ST_P1),
        .load_cur  (state_r == ST_P2),
        .load_down (state_r == ST_P3),
        .shift     (run),
        .rd_x      (rd_x),
        .rd_y      (rd_y),
        .res_x     (ec_x_in),
        .res_y     (ec_y_in),
        .up_x      (up_x),
        .up_y      (up_y),
        .cur_x     (cur_x),
        .cur_y     (cur_y),
        .down_x    (down_x),
        .down_y    (down_y)
    );

    // Last particle has no lower neighbour; mirror the current one into the down slot
    assign ec_up_x    = up_x;
    assign ec_up_y    = up_y;
    assign ec_x       = cur_x;
    assign ec_y       = cur_y;
    assign ec_down_x  = (run && at_last) ? cur_x : down_x;
    assign ec_down_y  = (run && at_last) ? cur_y : down_y;
    assign ec_is_last = run && at_last;

    assign wr_en   = run;
    assign wr_addr = run ? idx_r : '0;
    assign wr_x    = run ? ec_x_in : '0;
    assign wr_y    = run ? ec_y_in : '0;

    assign busy = (state_r != ST_IDLE) && (state_r != ST_DONE);
    assign done = (state_r == ST_DONE);

endmodule

// File: tb/tb_constraint_sweep_sequencer.sv
// Bench for constraint_sweep_sequencer: a cycle table on a 4-particle single-sweep instance
// and a scoreboard on a 5-particle three-sweep instance.
module tb_constraint_sweep_sequencer;
    import rope_pkg::*;

    localparam int NA = 4, AWA = 2, SA = 1;
    localparam int NB = 5, AWB = 3, SB = 3;
    localparam int W  = DATA_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input longint obs, input longint exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- DUT A: N=4, one sweep, pass-through constraint stub
    logic a_start = 1'b0;
    logic a_busy, a_done, a_rd_en, a_wr_en, a_ec_is_last;
    logic [AWA-1:0] a_rd_addr, a_wr_addr;
    logic signed [W-1:0] a_rd_x, a_rd_y, a_wr_x, a_wr_y;
    logic signed [W-1:0] a_ec_up_x, a_ec_up_y, a_ec_x, a_ec_y, a_ec_down_x, a_ec_down_y;
    logic signed [W-1:0] a_ec_x_in, a_ec_y_in;

    assign a_ec_x_in = a_ec_x;
    assign a_ec_y_in = a_ec_y;

    constraint_sweep_sequencer #(
        .N_PARTICLES(NA), .ADDR_W(AWA), .DATA_W(W), .NUM_SWEEPS(SA)
    ) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .busy(a_busy), .done(a_done),
        .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_x(a_rd_x), .rd_y(a_rd_y),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_x(a_wr_x), .wr_y(a_wr_y),
        .ec_up_x(a_ec_up_x), .ec_up_y(a_ec_up_y), .ec_x(a_ec_x), .ec_y(a_ec_y),
        .ec_down_x(a_ec_down_x), .ec_down_y(a_ec_down_y), .ec_is_last(a_ec_is_last),
        .ec_x_in(a_ec_x_in), .ec_y_in(a_ec_y_in)
    );

    pos_t ram_a [NA];
    pos_t img_a [NA];
    logic ld_a = 1'b0;

    always @(posedge clk) begin
        if (ld_a) begin
            for (int k = 0; k < NA; k++) ram_a[k] <= img_a[k];
        end else begin
            if (a_rd_en) begin
                a_rd_x <= ram_a[a_rd_addr].x;
                a_rd_y <= ram_a[a_rd_addr].y;
            end
            if (a_wr_en) ram_a[a_wr_addr] <= '{x: a_wr_x, y: a_wr_y};
        end
    end

    // ---------------- DUT B: N=5, three sweeps, stub selectable per run
    logic b_start = 1'b0;
    logic b_mode  = 1'b0;
    logic b_busy, b_done, b_rd_en, b_wr_en, b_ec_is_last;
    logic [AWB-1:0] b_rd_addr, b_wr_addr;
    logic signed [W-1:0] b_rd_x, b_rd_y, b_wr_x, b_wr_y;
    logic signed [W-1:0] b_ec_up_x, b_ec_up_y, b_ec_x, b_ec_y, b_ec_down_x, b_ec_down_y;
    logic signed [W-1:0] b_ec_x_in, b_ec_y_in;

    assign b_ec_x_in = b_mode ? (b_ec_up_x + 32'sd1) : b_ec_x;
    assign b_ec_y_in = b_ec_y;

    constraint_sweep_sequencer #(
        .N_PARTICLES(NB), .ADDR_W(AWB), .DATA_W(W), .NUM_SWEEPS(SB)
    ) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done),
        .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_x(b_rd_x), .rd_y(b_rd_y),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_x(b_wr_x), .wr_y(b_wr_y),
        .ec_up_x(b_ec_up_x), .ec_up_y(b_ec_up_y), .ec_x(b_ec_x), .ec_y(b_ec_y),
        .ec_down_x(b_ec_down_x), .ec_down_y(b_ec_down_y), .ec_is_last(b_ec_is_last),
        .ec_x_in(b_ec_x_in), .ec_y_in(b_ec_y_in)
    );

    pos_t ram_b [NB];
    pos_t img_b [NB];
    pos_t mdl_b [NB];
    logic ld_b = 1'b0;

    always @(posedge clk) begin
        if (ld_b) begin
            for (int k = 0; k < NB; k++) ram_b[k] <= img_b[k];
        end else begin
            if (b_rd_en) begin
                b_rd_x <= ram_b[b_rd_addr].x;
                b_rd_y <= ram_b[b_rd_addr].y;
            end
            if (b_wr_en) ram_b[b_wr_addr] <= '{x: b_wr_x, y: b_wr_y};
        end
    end

    // ---------------- scoreboard for DUT B
    typedef struct {
        int     cyc;
        int     addr;
        longint up_x;
        longint cur_x;
        longint down_x;
        longint wr_x;
        longint wr_y;
        bit     last;
    } wr_exp_t;

    wr_exp_t wr_q [$];
    int      rd_q [$];
    int      done_q [$];

    task automatic push_run(input int s, input bit mode);
        wr_exp_t e;
        logic signed [W-1:0] res;
        for (int sw = 0; sw < SB; sw++) begin
            for (int a = 0; a < NB; a++) rd_q.push_back(a);
            for (int i = 1; i < NB; i++) begin
                res      = mode ? (mdl_b[i-1].x + 32'sd1) : mdl_b[i].x;
                e.cyc    = s + 5 + sw * (NB + 3) + (i - 1);
                e.addr   = i;
                e.up_x   = mdl_b[i-1].x;
                e.cur_x  = mdl_b[i].x;
                e.down_x = (i == NB - 1) ? mdl_b[i].x : mdl_b[i+1].x;
                e.wr_x   = res;
                e.wr_y   = mdl_b[i].y;
                e.last   = (i == NB - 1);
                mdl_b[i].x = res;
                wr_q.push_back(e);
            end
        end
        done_q.push_back(s + 1 + SB * (NB + 3));
    endtask

    always @(negedge clk) begin : mon_b
        wr_exp_t e;
        if (!rst) begin
            if (b_rd_en) begin
                if (rd_q.size() == 0) check_val("b_rd_unexpected", 1, 0);
                else check_val("b_rd_addr", b_rd_addr, rd_q.pop_front());
            end
            if (b_wr_en) begin
                if (wr_q.size() == 0) begin
                    check_val("b_wr_unexpected", 1, 0);
                end else begin
                    e = wr_q.pop_front();
                    check_val("b_wr_cycle", cyc, e.cyc);
                    check_val("b_wr_addr", b_wr_addr, e.addr);
                    check_val("b_ec_up_x", b_ec_up_x, e.up_x);
                    check_val("b_ec_x", b_ec_x, e.cur_x);
                    check_val("b_ec_down_x", b_ec_down_x, e.down_x);
                    check_val("b_wr_x", b_wr_x, e.wr_x);
                    check_val("b_wr_y", b_wr_y, e.wr_y);
                    check_val("b_is_last", b_ec_is_last, e.last);
                end
            end
            if (b_done) begin
                if (done_q.size() == 0) check_val("b_done_unexpected", 1, 0);
                else check_val("b_done_cycle", cyc, done_q.pop_front());
            end
        end
    end

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_b(input bit mode, output int s);
        @(posedge clk);
        #1;
        b_mode  = mode;
        b_start = 1'b1;
        s = cyc;
        push_run(s, mode);
        @(posedge clk);
        #1;
        b_start = 1'b0;
        check_val("b_busy_after_start", b_busy, 1);
    endtask

    task automatic drain_b(input int budget);
        int k = 0;
        while ((wr_q.size() != 0 || done_q.size() != 0) && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        check_val("b_pending", wr_q.size() + done_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
        check_val("b_idle_busy", b_busy, 0);
    endtask

    initial begin
        int s;
        logic [W-1:0] ys [NA];
        ys[0] = 32'h000aae67; ys[1] = 32'h000b4e67; ys[2] = 32'h000c3e67; ys[3] = 32'h000d2e67;
        for (int k = 0; k < NA; k++) img_a[k] = '{x: 32'sh000c9b36, y: ys[k]};
        for (int k = 0; k < NB; k++) begin
            img_b[k] = '{x: W'(k + 1) <<< FRAC_BITS, y: -(W'(k + 2) <<< FRAC_BITS)};
            mdl_b[k] = img_b[k];
        end

        // reset state
        rst = 1'b1;
        ld_a = 1'b1;
        ld_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        ld_a = 1'b0;
        ld_b = 1'b0;
        @(negedge clk);
        check_val("rst_busy", b_busy, 0);
        check_val("rst_done", b_done, 0);
        check_val("rst_rd_en", b_rd_en, 0);
        check_val("rst_wr_en", b_wr_en, 0);
        check_val("rst_is_last", b_ec_is_last, 0);
        check_val("rst_wr_addr", b_wr_addr, 0);
        check_val("rst_ec_up_x", b_ec_up_x, 0);
        check_val("rst_a_busy", a_busy, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // cycle table on DUT A, start high in relative cycle 0
        @(posedge clk);
        #1;
        a_start = 1'b1;
        s = cyc;
        for (int r = 0; r < 10; r++) begin
            @(negedge clk);
            if (r == 1) a_start = 1'b0;
            check_val($sformatf("a_rd_en@%0d", r), a_rd_en, (r >= 1 && r <= 4));
            if (r >= 1 && r <= 4) check_val($sformatf("a_rd_addr@%0d", r), a_rd_addr, r - 1);
            check_val($sformatf("a_wr_en@%0d", r), a_wr_en, (r >= 5 && r <= 7));
            if (r >= 5 && r <= 7) begin
                check_val($sformatf("a_wr_addr@%0d", r), a_wr_addr, r - 4);
                check_val($sformatf("a_wr_x@%0d", r), a_wr_x, 32'h000c9b36);
            end
            check_val($sformatf("a_is_last@%0d", r), a_ec_is_last, (r == 7));
            check_val($sformatf("a_done@%0d", r), a_done, (r == 8));
            check_val($sformatf("a_busy@%0d", r), a_busy, (r >= 1 && r <= 7));
            if (r == 5) begin
                check_val("a_win_up_y", a_ec_up_y, 32'h000aae67);
                check_val("a_win_cur_y", a_ec_y, 32'h000b4e67);
                check_val("a_win_down_y", a_ec_down_y, 32'h000c3e67);
                check_val("a_win_up_x", a_ec_up_x, 32'h000c9b36);
                check_val("a_win_cur_x", a_ec_x, 32'h000c9b36);
            end
        end
        check_val("a_cycle_base", cyc - s, 9);
        check_val("a_p0_y", ram_a[0].y, 32'h000aae67);
        for (int k = 0; k < NA; k++) check_val($sformatf("a_ram_x%0d", k), ram_a[k].x, 32'h000c9b36);

        // DUT B pass-through, with start pulses during RUN and in DONE
        start_b(1'b0, s);
        wait_cyc(s + 6);
        b_start = 1'b1;
        @(posedge clk);
        #1;
        b_start = 1'b0;
        wait_cyc(s + 1 + SB * (NB + 3));
        b_start = 1'b1;
        @(posedge clk);
        #1;
        b_start = 1'b0;
        drain_b(100);

        // Gauss-Seidel: each particle becomes its just-enforced upper neighbour + 1 LSB
        start_b(1'b1, s);
        drain_b(100);
        for (int k = 0; k < NB; k++) check_val($sformatf("b_ram_x%0d", k), ram_b[k].x, mdl_b[k].x);

        // reset in RUN at i=2, then a fresh run
        start_b(1'b0, s);
        wait_cyc(s + 6);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        wr_q.delete();
        rd_q.delete();
        done_q.delete();
        check_val("rst_mid_busy", b_busy, 0);
        check_val("rst_mid_wr_en", b_wr_en, 0);
        check_val("rst_mid_rd_en", b_rd_en, 0);
        check_val("rst_mid_done", b_done, 0);
        repeat (12) @(posedge clk);
        #1;
        check_val("rst_mid_still_idle", b_busy, 0);
        start_b(1'b0, s);
        drain_b(100);
        check_val("b_rd_left", rd_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
